// File: rtl/piece_move_controller_pkg.sv
// Shared types and constants for the active-piece move sequencer.
package piece_move_controller_pkg;

   typedef enum logic [2:0] {
      CMD_SPAWN  = 3'd0,
      CMD_LEFT   = 3'd1,
      CMD_RIGHT  = 3'd2,
      CMD_DOWN   = 3'd3,
      CMD_ROTATE = 3'd4
   } piece_cmd_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAMPLE,
      S_CHECK,
      S_DONE
   } move_ctrl_state_e;

   localparam int SPAWN_X_DEFAULT = 3;

   // Candidate offsets in 2-bit two's complement.
   localparam logic [1:0] OFS_NEG  = 2'b11;
   localparam logic [1:0] OFS_ZERO = 2'b00;
   localparam logic [1:0] OFS_POS  = 2'b01;

endpackage

// File: rtl/piece_move_controller_if.sv
// Command handshake and completion pulses between the command source and the move sequencer.
interface piece_move_controller_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;
   logic       done;
   logic       accepted;
   logic       lock;

   modport master (output cmd_valid, cmd, input cmd_ready, done, accepted, lock);
   modport slave  (input cmd_valid, cmd, output cmd_ready, done, accepted, lock);
endinterface

// File: rtl/piece_move_controller_checker.sv
// Combinational overlap test of a 4x4 shape against a 6x6 window shifted by (dx, dy).
module piece_collision_checker (
   input  logic [15:0]     shape_i,
   input  logic [5:0][5:0] window_i,
   input  logic [1:0]      dx_i,
   input  logic [1:0]      dy_i,
   output logic            hit_o
);
   logic [1:0]  xi;
   logic [1:0]  yi;
   logic [15:0] cell_hit;

   // Offset -1/0/+1 maps to neighbourhood index 0/1/2.
   assign xi = dx_i + 2'd1;
   assign yi = dy_i + 2'd1;

   for (genvar gx = 0; gx < 4; gx++) begin : g_x
      for (genvar gy = 0; gy < 4; gy++) begin : g_y
         logic [2:0][2:0] nb;
         for (genvar i = 0; i < 3; i++) begin : g_i
            for (genvar j = 0; j < 3; j++) begin : g_j
               assign nb[i][j] = window_i[gx+i][gy+j];
            end
         end
         assign cell_hit[gy*4+gx] = shape_i[gy*4+gx] & nb[xi][yi];
      end
   end

   assign hit_o = |cell_hit;
endmodule

// File: rtl/piece_move_controller.sv
// Holds the authoritative piece position/rotation and runs each command through sample, check, commit.
module piece_move_controller
   import piece_move_controller_pkg::*;
#(
   parameter int BOARD_WIDTH  = 10,
   parameter int BOARD_HEIGHT = 20,
   parameter int SPAWN_X      = SPAWN_X_DEFAULT,
   localparam int XW = $clog2(BOARD_WIDTH),
   localparam int YW = $clog2(BOARD_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   piece_move_controller_if.slave cmd_if,
   input  logic [15:0]            piece_shape_i,
   input  logic [15:0]            rot_shape_i,
   input  logic [5:0][5:0]        window_i,
   output logic [XW-1:0]          mask_x_o,
   output logic [YW-1:0]          mask_y_o,
   output logic [XW-1:0]          piece_x_o,
   output logic [YW-1:0]          piece_y_o,
   output logic [1:0]             rot_o,
   output logic                   active_o,
   output logic                   game_over_o
);
   localparam logic [XW-1:0] X_SPAWN = XW'(SPAWN_X);
   localparam logic [XW-1:0] X_MAX   = XW'(BOARD_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(BOARD_HEIGHT - 1);

   move_ctrl_state_e state_q, state_d;
   logic [2:0]       cmd_q, cmd_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [1:0]       rot_q, rot_d;
   logic             active_q, active_d;
   logic             over_q, over_d;
   logic [5:0][5:0]  win_q, win_d;
   logic [15:0]      shape_q, shape_d;
   logic             acc_q, acc_d;
   logic             lock_q, lock_d;

   logic [1:0] dx, dy;
   logic       hit, forced, commit, down_lock, spawn_hit, legal;

   piece_collision_checker u_chk (
      .shape_i  (shape_q),
      .window_i (win_q),
      .dx_i     (dx),
      .dy_i     (dy),
      .hit_o    (hit)
   );

   always_comb begin
      dx = OFS_ZERO;
      dy = OFS_ZERO;
      case (cmd_q)
         CMD_LEFT:  dx = OFS_NEG;
         CMD_RIGHT: dx = OFS_POS;
         CMD_DOWN:  dy = OFS_POS;
         default:   ;
      endcase
   end

   always_comb begin
      legal     = (cmd_q <= CMD_ROTATE);
      forced    = !legal
                | ((cmd_q != CMD_SPAWN) && !active_q)
                | ((cmd_q == CMD_SPAWN) && over_q)
                | ((cmd_q == CMD_LEFT)  && (x_q == '0))
                | ((cmd_q == CMD_RIGHT) && (x_q == X_MAX))
                | ((cmd_q == CMD_DOWN)  && (y_q == Y_MAX));
      commit    = !forced && !hit;
      // Bottom row counts as a hit so a piece resting there still locks.
      down_lock = (cmd_q == CMD_DOWN) && active_q && (hit || (y_q == Y_MAX));
      spawn_hit = (cmd_q == CMD_SPAWN) && !over_q && hit;
   end

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      x_d      = x_q;
      y_d      = y_q;
      rot_d    = rot_q;
      active_d = active_q;
      over_d   = over_q;
      win_d    = win_q;
      shape_d  = shape_q;
      acc_d    = acc_q;
      lock_d   = lock_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_if.cmd_valid) begin
               state_d = S_SAMPLE;
               cmd_d   = cmd_if.cmd;
               if (cmd_if.cmd == CMD_SPAWN) rot_d = 2'd0;
            end
         end
         S_SAMPLE: begin
            win_d   = window_i;
            shape_d = (cmd_q == CMD_ROTATE) ? rot_shape_i : piece_shape_i;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = S_DONE;
            acc_d   = commit;
            lock_d  = down_lock;
            if (commit) begin
               case (cmd_q)
                  CMD_LEFT:   x_d = x_q - XW'(1);
                  CMD_RIGHT:  x_d = x_q + XW'(1);
                  CMD_DOWN:   y_d = y_q + YW'(1);
                  CMD_ROTATE: rot_d = rot_q + 2'd1;
                  CMD_SPAWN: begin
                     x_d      = X_SPAWN;
                     y_d      = '0;
                     active_d = 1'b1;
                  end
                  default: ;
               endcase
            end
            if (down_lock) active_d = 1'b0;
            if (spawn_hit) begin
               over_d   = 1'b1;
               active_d = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cmd_q    <= CMD_SPAWN;
         x_q      <= X_SPAWN;
         y_q      <= '0;
         rot_q    <= 2'd0;
         active_q <= 1'b0;
         over_q   <= 1'b0;
         win_q    <= '0;
         shape_q  <= '0;
         acc_q    <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         x_q      <= x_d;
         y_q      <= y_d;
         rot_q    <= rot_d;
         active_q <= active_d;
         over_q   <= over_d;
         win_q    <= win_d;
         shape_q  <= shape_d;
         acc_q    <= acc_d;
         lock_q   <= lock_d;
      end
   end

   // cmd_q resets to SPAWN, so the sampler address idles at the spawn point.
   assign mask_x_o = (cmd_q == CMD_SPAWN) ? X_SPAWN : x_q;
   assign mask_y_o = (cmd_q == CMD_SPAWN) ? '0 : y_q;

   assign cmd_if.cmd_ready = (state_q == S_IDLE);
   assign cmd_if.done      = (state_q == S_DONE);
   assign cmd_if.accepted  = (state_q == S_DONE) && acc_q;
   assign cmd_if.lock      = (state_q == S_DONE) && lock_q;

   assign piece_x_o   = x_q;
   assign piece_y_o   = y_q;
   assign rot_o       = rot_q;
   assign active_o    = active_q;
   assign game_over_o = over_q;
endmodule

// File: tb/tb_piece_move_controller.sv
// Directed bench: board model drives the sampler window, a board-coordinate model predicts every cycle.
module tb_piece_move_controller;
   localparam int W  = 10;
   localparam int H  = 20;
   localparam int SX = 3;

   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;

   piece_move_controller_if intf ();

   logic [15:0]     piece_shape, rot_shape;
   logic [5:0][5:0] window;
   logic [3:0]      mask_x, piece_x;
   logic [4:0]      mask_y, piece_y;
   logic [1:0]      rot;
   logic            active, game_over;

   piece_move_controller #(.BOARD_WIDTH(W), .BOARD_HEIGHT(H), .SPAWN_X(SX)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_if        (intf),
      .piece_shape_i (piece_shape),
      .rot_shape_i   (rot_shape),
      .window_i      (window),
      .mask_x_o      (mask_x),
      .mask_y_o      (mask_y),
      .piece_x_o     (piece_x),
      .piece_y_o     (piece_y),
      .rot_o         (rot),
      .active_o      (active),
      .game_over_o   (game_over)
   );

   bit board [0:H-1][0:W-1];
   bit piece_is_o = 1;
   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   function automatic logic [15:0] shape_of(logic [1:0] r);
      if (piece_is_o) return 16'h0033;
      case (r)
         2'd0:    return 16'h000F;
         2'd1:    return 16'h4444;
         2'd2:    return 16'h0F00;
         default: return 16'h2222;
      endcase
   endfunction

   function automatic bit occ(int x, int y);
      if (x < 0 || x >= W || y < 0 || y >= H) return 1'b1;
      return board[y][x];
   endfunction

   always_comb begin
      piece_shape = shape_of(rot);
      rot_shape   = shape_of(rot + 2'd1);
   end

   always_comb begin
      window = '0;
      for (int lx = 0; lx < 6; lx++)
         for (int ly = 0; ly < 6; ly++)
            window[lx][ly] = occ(int'(mask_x) - 1 + lx, int'(mask_y) - 1 + ly);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   typedef struct packed {
      logic       acc, lock, act, over;
      logic [3:0] x;
      logic [4:0] y;
      logic [1:0] rot;
   } res_t;

   int         m_phase = 0;
   logic [2:0] m_cmd = 0;
   logic [3:0] m_x = SX;
   logic [4:0] m_y = 0;
   logic [1:0] m_rot = 0;
   logic       m_act = 0, m_over = 0, m_acc = 0, m_lock = 0;
   res_t       m_res;

   function automatic res_t eval();
      res_t r;
      int dx, dy, bx, by;
      bit hit, forced;
      logic [15:0] sh;
      r = '{acc:1'b0, lock:1'b0, act:m_act, over:m_over, x:m_x, y:m_y, rot:m_rot};
      dx = (m_cmd == 1) ? -1 : (m_cmd == 2) ? 1 : 0;
      dy = (m_cmd == 3) ? 1 : 0;
      sh = (m_cmd == 4) ? shape_of(m_rot + 2'd1) : shape_of(m_rot);
      bx = (m_cmd == 0) ? SX : int'(m_x);
      by = (m_cmd == 0) ? 0 : int'(m_y);
      hit = 0;
      for (int sy = 0; sy < 4; sy++)
         for (int sx = 0; sx < 4; sx++)
            if (sh[sy*4+sx] && occ(bx + sx + dx, by + sy + dy)) hit = 1;
      forced = (m_cmd > 4) || (m_cmd != 0 && !m_act) || (m_cmd == 0 && m_over)
             || (m_cmd == 1 && m_x == 0) || (m_cmd == 2 && m_x == W-1)
             || (m_cmd == 3 && m_y == H-1);
      if (!forced && !hit) begin
         r.acc = 1;
         r.x   = 4'(bx + dx);
         r.y   = 5'(by + dy);
         if (m_cmd == 4) r.rot = m_rot + 2'd1;
         if (m_cmd == 0) r.act = 1;
      end else begin
         if (m_cmd == 3 && m_act) begin r.lock = 1; r.act = 0; end
         if (m_cmd == 0 && !m_over && hit) begin r.over = 1; r.act = 0; end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase <= 0; m_cmd <= 0; m_x <= SX; m_y <= 0; m_rot <= 0;
         m_act <= 0; m_over <= 0; m_acc <= 0; m_lock <= 0;
      end else begin
         case (m_phase)
            0: if (intf.cmd_valid) begin
                  m_phase <= 1;
                  m_cmd   <= intf.cmd;
                  if (intf.cmd == 0) m_rot <= 0;
               end
            1: begin m_res <= eval(); m_phase <= 2; end
            2: begin
                  m_x <= m_res.x; m_y <= m_res.y; m_rot <= m_res.rot;
                  m_act <= m_res.act; m_over <= m_res.over;
                  m_acc <= m_res.acc; m_lock <= m_res.lock;
                  m_phase <= 3;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ready",    16'(intf.cmd_ready), 16'(m_phase == 0));
         chk("m_done",     16'(intf.done),      16'(m_phase == 3));
         chk("m_accepted", 16'(intf.accepted),  16'(m_phase == 3 && m_acc));
         chk("m_lock",     16'(intf.lock),      16'(m_phase == 3 && m_lock));
         chk("m_x",        16'(piece_x),        16'(m_x));
         chk("m_y",        16'(piece_y),        16'(m_y));
         chk("m_rot",      16'(rot),            16'(m_rot));
         chk("m_active",   16'(active),         16'(m_act));
         chk("m_over",     16'(game_over),      16'(m_over));
         if (m_phase == 1) begin
            chk("m_mask_x", 16'(mask_x), (m_cmd == 0) ? 16'(SX) : 16'(m_x));
            chk("m_mask_y", 16'(mask_y), (m_cmd == 0) ? 16'd0 : 16'(m_y));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_board();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) board[y][x] = 0;
   endtask

   task automatic do_cmd(input logic [2:0] c, input logic ea, input logic el, input string nm);
      int n = 0;
      @(negedge clk);
      while (!intf.cmd_ready && n < 10) begin @(negedge clk); n++; end
      if (!intf.cmd_ready) begin
         chk({nm, "_ready_timeout"}, 16'(intf.cmd_ready), 16'd1);
         return;
      end
      intf.cmd = c;
      intf.cmd_valid = 1;
      @(posedge clk);
      #1 intf.cmd_valid = 0;
      @(negedge clk);
      @(negedge clk);
      chk({nm, "_done_early"}, 16'(intf.done), 16'd0);
      @(negedge clk);
      chk({nm, "_done"},     16'(intf.done),     16'd1);
      chk({nm, "_accepted"}, 16'(intf.accepted), 16'(ea));
      chk({nm, "_lock"},     16'(intf.lock),     16'(el));
   endtask

   initial begin
      int hs;
      intf.cmd_valid = 0;
      intf.cmd = 0;
      clear_board();
      repeat (3) @(posedge clk);
      chk_en = 1;
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_ready",  16'(intf.cmd_ready), 16'd1);
      chk("rst_x",      16'(piece_x), 16'd3);
      chk("rst_y",      16'(piece_y), 16'd0);
      chk("rst_active", 16'(active), 16'd0);
      chk("rst_mask_x", 16'(mask_x), 16'd3);
      chk("rst_mask_y", 16'(mask_y), 16'd0);

      // empty-board spawn, then bumping against the left wall
      piece_is_o = 1;
      do_cmd(3'd0, 1, 0, "spawn1");
      chk("spawn1_active", 16'(active), 16'd1);
      chk("spawn1_x", 16'(piece_x), 16'd3);
      for (int i = 0; i < 3; i++) do_cmd(3'd1, 1, 0, "left");
      chk("left_x0", 16'(piece_x), 16'd0);
      do_cmd(3'd1, 0, 0, "left_wall");
      do_cmd(3'd2, 1, 0, "right1");
      do_cmd(3'd2, 1, 0, "right2");
      chk("right_x2", 16'(piece_x), 16'd2);
      board[0][1] = 1;
      do_cmd(3'd1, 0, 0, "left_blocked");
      board[0][1] = 0;
      do_cmd(3'd5, 0, 0, "illegal");

      // held-valid throughput: four O rotations in sixteen cycles
      @(negedge clk);
      intf.cmd = 3'd4;
      intf.cmd_valid = 1;
      hs = 0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         if (intf.cmd_ready) hs++;
      end
      intf.cmd_valid = 0;
      chk("stall_count", 16'(hs), 16'd4);
      chk("stall_rot", 16'(rot), 16'd0);

      // drop onto a full bottom row
      piece_is_o = 0;
      for (int x = 0; x < W; x++) board[H-1][x] = 1;
      do_cmd(3'd0, 1, 0, "spawn_i");
      for (int i = 0; i < 17; i++) do_cmd(3'd3, 1, 0, "down");
      chk("down_y17", 16'(piece_y), 16'd17);
      do_cmd(3'd3, 1, 0, "down18");
      chk("down_y18", 16'(piece_y), 16'd18);
      do_cmd(3'd3, 0, 1, "down_lock");
      chk("lock_active", 16'(active), 16'd0);
      chk("lock_y", 16'(piece_y), 16'd18);
      do_cmd(3'd3, 0, 0, "down_inactive");

      // rotation into an occupied cell
      clear_board();
      do_cmd(3'd0, 1, 0, "spawn_rot");
      board[2][5] = 1;
      do_cmd(3'd4, 0, 0, "rot_blocked");
      chk("rot_blocked_rot", 16'(rot), 16'd0);
      board[2][5] = 0;
      do_cmd(3'd4, 1, 0, "rot_ok");
      chk("rot_ok_rot", 16'(rot), 16'd1);
      do_cmd(3'd1, 1, 0, "left_i");
      chk("left_i_x", 16'(piece_x), 16'd2);

      // spawn into a filled spawn area
      piece_is_o = 1;
      for (int x = 3; x <= 6; x++) board[0][x] = 1;
      do_cmd(3'd0, 0, 0, "spawn_over");
      chk("over_flag", 16'(game_over), 16'd1);
      chk("over_active", 16'(active), 16'd0);
      do_cmd(3'd0, 0, 0, "spawn_after_over");
      do_cmd(3'd1, 0, 0, "left_inactive");

      // reset during CHECK aborts the command
      @(negedge clk);
      intf.cmd = 3'd2;
      intf.cmd_valid = 1;
      @(posedge clk);
      #1 intf.cmd_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      chk("rst2_done",  16'(intf.done), 16'd0);
      chk("rst2_ready", 16'(intf.cmd_ready), 16'd1);
      chk("rst2_over",  16'(game_over), 16'd0);
      chk("rst2_x",     16'(piece_x), 16'd3);
      rst_n = 1;
      @(negedge clk);
      chk("rst2_done_after", 16'(intf.done), 16'd0);
      clear_board();
      do_cmd(3'd0, 1, 0, "spawn_post_rst");
      chk("post_rst_active", 16'(active), 16'd1);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
